// File: rtl/rf_ckpt_ctrl_pkg.sv
// Shared defaults and types for the register-file checkpoint manager.
package rf_ckpt_ctrl_pkg;

  localparam int DEF_DW       = 6;
  localparam int DEF_AW       = 5;
  localparam int DEF_NUM_CKPT = 4;
  localparam int DEF_CIW      = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RESTORE = 1'b1
  } state_t;

endpackage

// File: rtl/rf_ckpt_ctrl_if.sv
// Bundle between the checkpoint manager and its dispatch/commit/flush client and the RF.
interface rf_ckpt_ctrl_if
  import rf_ckpt_ctrl_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int AW  = DEF_AW,
  parameter int CIW = DEF_CIW
);
  localparam int IW = DW * (1 << AW);

  logic [IW-1:0]  i_rf_do;
  logic           i_take;
  logic           o_take_rdy;
  logic [CIW-1:0] o_take_id;
  logic           i_commit;
  logic           i_flush;
  logic [CIW-1:0] i_flush_id;
  logic           o_rep;
  logic [IW-1:0]  o_di;
  logic [CIW:0]   o_count;
  logic           o_flush_err;

  modport master (
    output i_rf_do, i_take, i_commit, i_flush, i_flush_id,
    input  o_take_rdy, o_take_id, o_rep, o_di, o_count, o_flush_err
  );

  modport slave (
    input  i_rf_do, i_take, i_commit, i_flush, i_flush_id,
    output o_take_rdy, o_take_id, o_rep, o_di, o_count, o_flush_err
  );

endinterface

// File: rtl/rf_ckpt_ctrl_store.sv
// Checkpoint image storage: one write port, one asynchronous read port, no reset.
module rf_ckpt_ctrl_store
  import rf_ckpt_ctrl_pkg::*;
#(
  parameter int W   = DEF_DW * (1 << DEF_AW),
  parameter int N   = DEF_NUM_CKPT,
  parameter int CIW = DEF_CIW
) (
  input  logic           CLK,
  input  logic           we,
  input  logic [CIW-1:0] waddr,
  input  logic [W-1:0]   wdata,
  input  logic [CIW-1:0] raddr,
  output logic [W-1:0]   rdata
);

  logic [W-1:0] mem [N];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rf_ckpt_ctrl.sv
// Checkpoint manager: snapshots the RF image on take, frees in order on commit,
// and replays a saved image through a one-cycle REP pulse on flush.
module rf_ckpt_ctrl
  import rf_ckpt_ctrl_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int NUM_CKPT = DEF_NUM_CKPT,
  parameter int CIW      = DEF_CIW
) (
  input  logic         CLK,
  input  logic         RST,
  rf_ckpt_ctrl_if.slave bus
);

  localparam int           IW   = DW * (1 << AW);
  localparam logic [CIW:0] FULL = (CIW+1)'(NUM_CKPT);

  state_t         state_reg, state_next;
  logic [CIW-1:0] head_reg, tail_reg, rid_reg;
  logic [CIW:0]   count_reg;
  logic           rep_reg, err_reg;

  logic           take_rdy, take_acc;
  logic           flush_acc, commit_ok, commit_eff, flush_ok;
  logic [CIW-1:0] head_post, flush_dist;
  logic [CIW:0]   count_post;
  logic [IW-1:0]  store_rdata;

  // A commit racing a flush aimed at the head would free the very target, so it is dropped;
  // validity and the rolled-back count are then measured from the post-commit head.
  assign flush_acc  = bus.i_flush & (state_reg == ST_IDLE);
  assign commit_ok  = bus.i_commit & (count_reg != '0);
  assign commit_eff = commit_ok & ~(flush_acc & (head_reg == bus.i_flush_id));
  assign head_post  = head_reg + CIW'(commit_eff);
  assign count_post = count_reg - (CIW+1)'(commit_eff);
  assign flush_dist = bus.i_flush_id - head_post;
  assign flush_ok   = flush_acc & ({1'b0, flush_dist} < count_post);
  assign take_acc   = bus.i_take & take_rdy;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= ST_IDLE;
      rep_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      rep_reg   <= (state_next == ST_RESTORE);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (flush_ok) state_next = ST_RESTORE;
      ST_RESTORE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    take_rdy = (count_reg != FULL) & (state_reg == ST_IDLE) & ~bus.i_flush;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      rid_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      head_reg <= head_post;
      err_reg  <= flush_acc & ~flush_ok;
      if (flush_ok) begin
        tail_reg  <= bus.i_flush_id;
        count_reg <= {1'b0, flush_dist};
        rid_reg   <= bus.i_flush_id;
      end else begin
        tail_reg  <= tail_reg + CIW'(take_acc);
        count_reg <= count_post + (CIW+1)'(take_acc);
      end
    end
  end

  rf_ckpt_ctrl_store #(
    .W   (IW),
    .N   (NUM_CKPT),
    .CIW (CIW)
  ) u_store (
    .CLK   (CLK),
    .we    (take_acc),
    .waddr (tail_reg),
    .wdata (bus.i_rf_do),
    .raddr (rid_reg),
    .rdata (store_rdata)
  );

  assign bus.o_take_rdy  = take_rdy;
  assign bus.o_take_id   = tail_reg;
  assign bus.o_count     = count_reg;
  assign bus.o_rep       = rep_reg;
  assign bus.o_di        = store_rdata;
  assign bus.o_flush_err = err_reg;

endmodule
